// File: rtl/alu.sv
// Registered WIDTH-bit ALU: sixteen opcodes, one-cycle latency, synchronous active-high reset.
// Define ALU_FLAGS_EN to add the registered zero and signed-overflow flag outputs.
module alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] out,
    output logic             carryout
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_NAND = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_XNOR = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_SHL  = 4'b1010,
        OP_SHR  = 4'b1011,
        OP_ROL  = 4'b1100,
        OP_ROR  = 4'b1101,
        OP_INC  = 4'b1110,
        OP_CLR  = 4'b1111
    } op_t;

    op_t                op;
    logic [WIDTH-1:0]   res;
    logic               cy;
    logic [WIDTH:0]     wide;
    logic [2*WIDTH-1:0] prod;

    assign op   = op_t'(opcode);
    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);

    always_comb begin
        res  = '0;
        cy   = 1'b0;
        wide = '0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                {cy, res} = wide;
            end
            // The extended subtraction's top bit is the borrow (set iff a < b).
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                {cy, res} = wide;
            end
            OP_MUL: begin
                res = prod[WIDTH-1:0];
                cy  = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_NOT:  res = ~a;
            OP_SHL: begin
                res = {a[WIDTH-2:0], 1'b0};
                cy  = a[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, a[WIDTH-1:1]};
                cy  = a[0];
            end
            OP_ROL: begin
                res = {a[WIDTH-2:0], a[WIDTH-1]};
                cy  = a[WIDTH-1];
            end
            OP_ROR: begin
                res = {a[0], a[WIDTH-1:1]};
                cy  = a[0];
            end
            OP_INC: begin
                wide = {1'b0, a} + (WIDTH+1)'(1);
                {cy, res} = wide;
            end
            default: begin
                res = '0;
                cy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= '0;
            carryout <= 1'b0;
        end else begin
            out      <= res;
            carryout <= cy;
        end
    end

`ifdef ALU_FLAGS_EN
    logic ov;

    always_comb begin
        ov = 1'b0;
        case (op)
            OP_ADD:  ov = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  ov = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            OP_INC:  ov = !a[WIDTH-1] && res[WIDTH-1];
            default: ov = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            zero     <= (res == '0);
            overflow <= ov;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu (WIDTH=4): expected results are queued at drive time and
// compared one edge later; also checks that outputs hold while inputs change between edges.
module tb_alu;

    localparam int unsigned W = 4;

    typedef enum logic [3:0] {
        ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, AND_ = 4'd3, OR_ = 4'd4, XOR_ = 4'd5,
        NAND_ = 4'd6, NOR_ = 4'd7, XNOR_ = 4'd8, NOT_ = 4'd9, SHL = 4'd10,
        SHR = 4'd11, ROL = 4'd12, ROR = 4'd13, INC = 4'd14, CLR = 4'd15
    } op_t;

    typedef struct {
        int    o;
        int    c;
        int    z;
        int    v;
        string tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   opcode = '0;
    logic [W-1:0] out;
    logic         carryout;
`ifdef ALU_FLAGS_EN
    logic         zero;
    logic         overflow;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .out      (out),
        .carryout (carryout)
`ifdef ALU_FLAGS_EN
        ,
        .zero     (zero),
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Independent integer reference model for WIDTH=4.
    function automatic exp_t model(input int op, input int x, input int y, input bit r, input string tag);
        exp_t e;
        int   s;
        e.o = 0; e.c = 0; e.v = 0; e.tag = tag;
        if (!r) begin
            case (op)
                0:  begin s = x + y; e.o = s % 16; e.c = int'(s > 15);
                          s = sgn(x) + sgn(y); e.v = int'(s > 7 || s < -8); end
                1:  begin e.o = (x - y + 16) % 16; e.c = int'(x < y);
                          s = sgn(x) - sgn(y); e.v = int'(s > 7 || s < -8); end
                2:  begin s = x * y; e.o = s % 16; e.c = int'(s > 15); end
                3:  e.o = x & y;
                4:  e.o = x | y;
                5:  e.o = x ^ y;
                6:  e.o = 15 - (x & y);
                7:  e.o = 15 - (x | y);
                8:  e.o = 15 - (x ^ y);
                9:  e.o = 15 - x;
                10: begin e.o = (x * 2) % 16; e.c = int'(x >= 8); end
                11: begin e.o = x / 2; e.c = x % 2; end
                12: begin e.o = (x * 2) % 16 + x / 8; e.c = int'(x >= 8); end
                13: begin e.o = x / 2 + (x % 2) * 8; e.c = x % 2; end
                14: begin s = x + 1; e.o = s % 16; e.c = int'(s > 15); e.v = int'(x == 7); end
                default: e.o = 0;
            endcase
            e.z = int'(e.o == 0);
        end else begin
            e.z = 0;
        end
        return e;
    endfunction

    task automatic apply(input int op, input int x, input int y, input bit r, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; opcode = 4'(op); a = 4'(x); b = 4'(y);
        sb.push_back(model(op, x, y, r, tag));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_out"}, int'(out), e.o);
            check({e.tag, "_cy"}, int'(carryout), e.c);
`ifdef ALU_FLAGS_EN
            check({e.tag, "_zero"}, int'(zero), e.z);
            check({e.tag, "_ovf"}, int'(overflow), e.v);
`endif
            // Wiggle inputs mid-cycle; registered outputs must not move.
            a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); opcode = 4'($urandom_range(15));
            #3;
            check({e.tag, "_hold"}, int'({carryout, out}), e.c * 16 + e.o);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        apply(ADD, 15, 2, 1'b1, "reset");
        apply(ADD, 15, 2, 1'b0, "add_wrap");
        apply(SUB, 3, 2, 1'b0, "sub_nb");
        apply(SUB, 2, 3, 1'b0, "sub_borrow");
        apply(MUL, 3, 2, 1'b0, "mul_small");
        apply(MUL, 15, 2, 1'b0, "mul_ovf");
        for (int unsigned op = 3; op <= 14; op++)
            apply(int'(op), 3, 2, 1'b0, $sformatf("sweep_op%0d", op));
        apply(CLR, 9, 9, 1'b0, "clr");
        apply(ADD, 7, 1, 1'b0, "add_sovf");
        apply(SUB, 8, 1, 1'b0, "sub_sovf");
        apply(INC, 15, 0, 1'b0, "inc_wrap");
        apply(INC, 7, 0, 1'b0, "inc_sovf");
        apply(MUL, 15, 15, 1'b0, "mul_max");
        apply(ADD, 15, 2, 1'b1, "rst_mid");
        apply(ADD, 15, 2, 1'b0, "post_rst");
        for (int unsigned i = 0; i < 300; i++)
            apply(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
                  ($urandom_range(19) == 0), "rand");
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameter: WIDTH, default 4, operand/result width in bits; all values below are for WIDTH=4.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port a  input  WIDTH  operand 1, unsigned.
REQ-006 Port b  input  WIDTH  operand 2, unsigned.
REQ-007 Port opcode  input  4  operation select.
REQ-008 Port out  output  WIDTH  registered result.
REQ-009 Port carryout  output  1  registered carry/borrow/shifted-out bit.

Function
REQ-010 Inputs SHALL be sampled on each rising clk edge; out/carryout SHALL update on that edge, 1-cycle latency, with no enable or handshake.
REQ-011 Opcode map (result -> out, carry -> carryout):
  - 0000 ADD: {carryout,out} = a+b.
  - 0001 SUB: out = (a-b) mod 2^WIDTH; carryout = 1 iff a<b (borrow).
  - 0010 MUL: out = low WIDTH bits of a*b; carryout = 1 iff the product exceeds 2^WIDTH-1.
  - 0011 AND, 0100 OR, 0101 XOR, 0110 NAND, 0111 NOR, 1000 XNOR: bitwise a op b; carryout=0.
  - 1001 NOT: out = ~a; carryout=0.
  - 1010 SHL: out = a<<1, LSB filled with 0; carryout = a[MSB].
  - 1011 SHR: out = a>>1 logical, MSB filled with 0; carryout = a[0].
  - 1100 ROL: out = {a[MSB-1:0],a[MSB]}; carryout = a[MSB].
  - 1101 ROR: out = {a[0],a[MSB:1]}; carryout = a[0].
  - 1110 INC: {carryout,out} = a+1.
  - 1111 CLR: out=0, carryout=0.
REQ-012 Arithmetic SHALL be unsigned and wrap modulo 2^WIDTH; no saturation.
REQ-013 b SHALL be ignored for opcodes 1001-1111.
REQ-014 An opcode change SHALL take effect on the next edge with no pipeline residue; back-to-back opcodes produce back-to-back results.
REQ-015 Outputs SHALL hold their value between edges regardless of input changes (no combinational path from inputs to outputs).

Reset
REQ-016 When rst=1 at a rising edge, out SHALL become 0 and carryout SHALL become 0, overriding any opcode.
REQ-017 Reset asserted mid-stream SHALL discard the in-flight result; the first result after rst deasserts SHALL be the operation sampled on the first edge with rst=0.
REQ-018 Before the first reset, output values SHALL be don't-care.

Configuration
REQ-019 Macro ALU_FLAGS_EN: when defined, two extra registered outputs SHALL exist: zero (1 bit, 1 iff the next out==0) and overflow (1 bit, signed two's-complement overflow for ADD/SUB/INC, 0 for all other opcodes); both SHALL reset to 0 and update with the same timing as out.
REQ-020 When ALU_FLAGS_EN is not defined, the zero and overflow ports SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-021 ADD a=1111 b=0010 -> after one edge: out=0001, carryout=1.
REQ-022 SUB a=0011 b=0010 -> out=0001, carryout=0; SUB a=0010 b=0011 -> out=1111, carryout=1.
REQ-023 MUL a=0011 b=0010 -> out=0110, carryout=0; MUL a=1111 b=0010 -> out=1110, carryout=1.
REQ-024 Sweep opcodes 0011-1110 with a=0011 b=0010 -> AND 0010, OR 0011, XOR 0001, NAND 1101, NOR 1100, XNOR 1110, NOT 1100, SHL 0110/c0, SHR 0001/c1, ROL 0110/c0, ROR 1001/c1, INC 0100/c0.
REQ-025 Reset mid-stream: ADD a=1111 b=0010 with rst=1 on the same edge -> out=0000, carryout=0; rst=0 next edge -> out=0001, carryout=1.
REQ-026 With ALU_FLAGS_EN: CLR -> zero=1; ADD a=0111 b=0001 -> out=1000, overflow=1, zero=0.
